gray_sync_decoder: RTL and testbench
====================================

# gray_sync_decoder

Input stage of the Gray decoder datapath: takes the 4-bit Gray code from the board switches, synchronises and debounces it, converts it to binary, and splits the result into tens/units BCD digits. The registered outputs feed the binary-to-7-segment digit converters directly downstream. A one-cycle `nuevo` strobe marks every committed value change.

## Interface
- `WIDTH`, 4: Gray/binary word width; fixed at 4 in this design.
- `DEBOUNCE_CYCLES`, 50000: cycles the synchronised input must hold before commit; 1 ms at 50 MHz; minimum 2.

- `reloj`  in  1  system clock, 50 MHz, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `gray_in`  in  4  raw switch Gray code; asynchronous to `reloj`.
- `bin_out`  out  4  committed binary value, registered.
- `bcd_d`  out  4  tens digit of `bin_out`, 0 or 1, registered.
- `bcd_u`  out  4  units digit of `bin_out`, 0–9, registered.
- `nuevo`  out  1  one-cycle pulse, high in the cycle in which new outputs first appear.

## Operation
- **Synchroniser.** 2-FF chain: `gray_in` → `sync_q1` → `sync_q2`. Both flops reset to 0.
- **Internal registers.** `stable_gray` is the last committed code, reset 0. `cand` is the candidate code. `cnt` is the debounce counter, width `$clog2(DEBOUNCE_CYCLES)`.
- **FSM states:** STABLE (reset state), PENDING, COMMIT.
  - **STABLE:** if `sync_q2 != stable_gray`, then `cand <= sync_q2`, `cnt <= 0`, go to PENDING. Otherwise hold.
  - **PENDING:**
    - If `sync_q2 == stable_gray`, the bounce returned to the old value: abort to STABLE with no output change.
    - Else if `sync_q2 != cand`, restart: `cand <= sync_q2`, `cnt <= 0`.
    - Else if `cnt == DEBOUNCE_CYCLES-1`, go to COMMIT.
    - Else `cnt <= cnt+1`.
  - **COMMIT:** unconditionally go to STABLE. On this edge:
    - `stable_gray <= cand`;
    - `bin_out <= gray2bin(cand)`;
    - `bcd_d`/`bcd_u` load from the same value;
    - `nuevo <= 1`.
- **`nuevo` width.** `nuevo` is 1 for exactly one cycle and is cleared on every other edge. Input changes during COMMIT are handled from STABLE on the next cycle.
- **Gray to binary:** `b[3]=g[3]`; `b[i]=b[i+1]^g[i]` for i = 2..0.
- **BCD split:** if `b >= 10`, then `bcd_d=1`, `bcd_u=b-10`; else `bcd_d=0`, `bcd_u=b`. Upper bits of `bcd_d` are always 0.
- **Reset values:** all outputs 0 (`bin_out=0`, `bcd_d=0`, `bcd_u=0`, `nuevo=0`). State STABLE, `cnt=0`, `cand=0`.
- **Reset mid-operation:** reset wins over every transition. A pending candidate is discarded and outputs return to 0 on the reset edge.

## Timing
- Let edge 0 be the first rising edge after `gray_in` changes and then holds.
- **With debounce:**
  - `sync_q2` valid after edge 1; PENDING from edge 2 with `cnt=0`.
  - `cnt` reaches `DEBOUNCE_CYCLES-1` at edge `DEBOUNCE_CYCLES+1`; COMMIT from edge `DEBOUNCE_CYCLES+2`.
  - Outputs and `nuevo` update at edge `DEBOUNCE_CYCLES+3`.
- **Glitch rejection:** any glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync_q2` produces no output change and no `nuevo`.
- Outputs are registered; there is no combinational path from `gray_in` to any output.

## Configuration
- **Macro:** `GRAY_DEBOUNCE_EN`.
- **Defined:** behaviour exactly as above.
- **Undefined:**
  - PENDING and `cnt` are not compiled; `DEBOUNCE_CYCLES` is ignored.
  - STABLE goes directly to COMMIT on `sync_q2 != stable_gray`, with `cand <= sync_q2`.
  - Outputs update at edge 3 (4th edge after the change).
  - The synchroniser is always present.

## Structure
- **Shared package `gray_pkg`:**
  - `localparam GRAY_W = 4`;
  - `typedef enum logic [1:0] {STABLE, PENDING, COMMIT} gray_state_t`;
  - `function gray2bin`;
  - `function bin2bcd` returning {tens, units}.
- **Sub-module `sync_2ff`:** a parameterised-width 2-flop synchroniser with synchronous active-high reset.
- FSM, counter and output registers live in `gray_sync_decoder`.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4` and a 20 ns clock.

- Reset asserted 3 cycles with `gray_in=4'b1010` → all outputs 0, `nuevo` 0 throughout reset.
- `gray_in` 0000→0110, held → at edge 7 `bin_out=4'd4`, `bcd_d=0`, `bcd_u=4`, `nuevo` high exactly 1 cycle.
- `gray_in`=1000, held → `bin_out=15`, `bcd_d=1`, `bcd_u=5`. Then `gray_in`=1111 → `bin_out=10`, `bcd_d=1`, `bcd_u=0`.
- From committed 0000, pulse `gray_in`=0001 for 2 cycles then back to 0000 → no output change, `nuevo` never asserted.
- Sweep all 16 Gray codes, each held 20 cycles → `bin_out` follows the binary sequence 0..15 on the matching codes. Exactly 16 `nuevo` pulses, or 15 if the sweep starts at 0000.
- Assert reset during PENDING (candidate 0011) → outputs stay/return to 0, no `nuevo`. After release with 0011 still held → commit `bin_out=2` at edge 7 after release.

Source files
------------

// File: rtl/gray_pkg.sv
`timescale 1ns/1ps
// gray_pkg
// Shared definitions for the Gray decoder input stage: word width, FSM
// state encoding and the two pure conversion helpers used when a value
// is committed.
//   GRAY_W        : Gray/binary word width (fixed at 4)
//   gray_state_t  : STABLE / PENDING / COMMIT
//   gray2bin()    : Gray code -> binary
//   bin2bcd()     : 4-bit binary -> {tens, units}, each 4 bits
package gray_pkg;

    localparam int GRAY_W = 4;

    typedef enum logic [1:0] {
        STABLE  = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } gray_state_t;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A 4-bit value never exceeds 15, so the tens digit is only ever 0 or 1.
    function automatic logic [7:0] bin2bcd(input logic [GRAY_W-1:0] b);
        logic [3:0] tens;
        logic [3:0] units;
        if (b >= 4'd10) begin
            tens  = 4'd1;
            units = b - 4'd10;
        end else begin
            tens  = 4'd0;
            units = b;
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// sync_2ff
// Two-flop synchroniser for a W-bit bus that is asynchronous to clk.
// The bus is treated as a unit; for switch inputs any mid-transition
// skew between bits is absorbed by the downstream debounce.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (both stages clear to 0)
//   d   : asynchronous input bus
//   q   : synchronised output (second stage)
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync_q1;
    logic [W-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= d;
            sync_q2 <= sync_q1;
        end
    end

    assign q = sync_q2;

endmodule

// File: rtl/gray_sync_decoder.sv
`timescale 1ns/1ps
// gray_sync_decoder
// Input stage of the Gray decoder datapath. Synchronises the switch Gray
// code, optionally debounces it, and on each committed change registers
// the binary value and its tens/units BCD digits together with a
// one-cycle 'nuevo' strobe.
//
// Build option: GRAY_DEBOUNCE_EN
//   defined   : a change must hold DEBOUNCE_CYCLES cycles at the
//               synchroniser output before it is committed.
//   undefined : any change at the synchroniser output commits directly;
//               DEBOUNCE_CYCLES is ignored.
//
// Ports:
//   reloj   : 50 MHz system clock, rising edge
//   reset   : synchronous, active-high reset
//   gray_in : raw switch Gray code (asynchronous)
//   bin_out : committed binary value
//   bcd_d   : tens digit of bin_out (0 or 1)
//   bcd_u   : units digit of bin_out (0..9)
//   nuevo   : one-cycle pulse in the cycle new outputs first appear
module gray_sync_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH           = GRAY_W,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic [3:0]       bcd_d,
    output logic [3:0]       bcd_u,
    output logic             nuevo
);

    logic [WIDTH-1:0] sync_q2;

    sync_2ff #(
        .W (WIDTH)
    ) u_sync (
        .clk (reloj),
        .rst (reset),
        .d   (gray_in),
        .q   (sync_q2)
    );

    gray_state_t      state_q,  state_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] cand_q,   cand_d;
    logic [WIDTH-1:0] bin_q,    bin_d;
    logic [3:0]       tens_q,   tens_d;
    logic [3:0]       units_q,  units_d;
    logic             nuevo_q,  nuevo_d;
    logic [WIDTH-1:0] cand_bin;

`ifdef GRAY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign cand_bin = gray2bin(cand_q);

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        cand_d   = cand_q;
        bin_d    = bin_q;
        tens_d   = tens_q;
        units_d  = units_q;
        nuevo_d  = 1'b0;
`ifdef GRAY_DEBOUNCE_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            STABLE: begin
                if (sync_q2 != stable_q) begin
                    cand_d  = sync_q2;
`ifdef GRAY_DEBOUNCE_EN
                    cnt_d   = '0;
                    state_d = PENDING;
`else
                    state_d = COMMIT;
`endif
                end
            end
`ifdef GRAY_DEBOUNCE_EN
            PENDING: begin
                if (sync_q2 == stable_q) begin
                    // bounced back to the committed code: drop the candidate
                    state_d = STABLE;
                end else if (sync_q2 != cand_q) begin
                    // moved to yet another code: restart the hold window
                    cand_d = sync_q2;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            COMMIT: begin
                // input changes seen here are picked up from STABLE next cycle
                state_d           = STABLE;
                stable_d          = cand_q;
                bin_d             = cand_bin;
                {tens_d, units_d} = bin2bcd(cand_bin);
                nuevo_d           = 1'b1;
            end
            default: begin
                state_d = STABLE;
            end
        endcase
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            state_q  <= STABLE;
            stable_q <= '0;
            cand_q   <= '0;
            bin_q    <= '0;
            tens_q   <= '0;
            units_q  <= '0;
            nuevo_q  <= 1'b0;
`ifdef GRAY_DEBOUNCE_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            bin_q    <= bin_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            nuevo_q  <= nuevo_d;
`ifdef GRAY_DEBOUNCE_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bin_out = bin_q;
    assign bcd_d   = tens_q;
    assign bcd_u   = units_q;
    assign nuevo   = nuevo_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
`timescale 1ns/1ps
// tb_gray_sync_decoder
// Directed-vector bench for gray_sync_decoder with DEBOUNCE_CYCLES=4 and a
// 20 ns clock. Latencies follow the build option: with GRAY_DEBOUNCE_EN
// outputs move at edge DEB+3 after an input change, otherwise at edge 3.
module tb_gray_sync_decoder;

    localparam int DEB = 4;
`ifdef GRAY_DEBOUNCE_EN
    localparam int LAT           = DEB + 3;
    localparam int PRE_RST       = 4;   // lands in PENDING with cnt=1
    localparam int GLITCH_PULSES = 0;
`else
    localparam int LAT           = 3;
    localparam int PRE_RST       = 2;   // reset hits the STABLE->COMMIT edge
    localparam int GLITCH_PULSES = 2;   // glitch commits, then the return commits
`endif

    logic       reloj = 1'b0;
    logic       reset;
    logic [3:0] gray_in;
    logic [3:0] bin_out;
    logic [3:0] bcd_d;
    logic [3:0] bcd_u;
    logic       nuevo;

    int n_chk  = 0;
    int n_pass = 0;
    int npulse = 0;

    // Gray codes for binary 0..15, worked out by hand.
    logic [3:0] gcode [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                               4'b0110, 4'b0111, 4'b0101, 4'b0100,
                               4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_sync_decoder #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .reloj   (reloj),
        .reset   (reset),
        .gray_in (gray_in),
        .bin_out (bin_out),
        .bcd_d   (bcd_d),
        .bcd_u   (bcd_u),
        .nuevo   (nuevo)
    );

    always #10 reloj = ~reloj;

    always @(negedge reloj) begin
        if (nuevo === 1'b1) npulse++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    // Drive a new code and check the exact edge on which it lands.
    task automatic apply(input logic [3:0] g, input logic [3:0] eb, input logic [3:0] ed,
                         input logic [3:0] eu, input logic [3:0] prev, input string tag);
        int p0;
        gray_in = g;
        repeat (LAT) tick();
        chk({tag, " early bin"}, 32'(bin_out), 32'(prev));
        chk({tag, " early nuevo"}, 32'(nuevo), 0);
        p0 = npulse;
        tick();
        chk({tag, " bin"}, 32'(bin_out), 32'(eb));
        chk({tag, " bcd_d"}, 32'(bcd_d), 32'(ed));
        chk({tag, " bcd_u"}, 32'(bcd_u), 32'(eu));
        chk({tag, " nuevo"}, 32'(nuevo), 1);
        tick();
        chk({tag, " nuevo drop"}, 32'(nuevo), 0);
        repeat (10) tick();
        chk({tag, " pulses"}, 32'(npulse - p0), 1);
        chk({tag, " hold bin"}, 32'(bin_out), 32'(eb));
    endtask

    initial begin
        int p0;

        // reset with a non-zero code present
        reset   = 1'b1;
        gray_in = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst bin", 32'(bin_out), 0);
            chk("rst bcd_d", 32'(bcd_d), 0);
            chk("rst bcd_u", 32'(bcd_u), 0);
            chk("rst nuevo", 32'(nuevo), 0);
        end
        reset   = 1'b0;
        gray_in = 4'b0000;
        repeat (10) tick();
        chk("idle bin", 32'(bin_out), 0);
        chk("idle pulses", 32'(npulse), 0);

        apply(4'b0110, 4'd4,  4'd0, 4'd4, 4'd0,  "g0110");
        apply(4'b1000, 4'd15, 4'd1, 4'd5, 4'd4,  "g1000");
        apply(4'b1111, 4'd10, 4'd1, 4'd0, 4'd15, "g1111");
        apply(4'b0000, 4'd0,  4'd0, 4'd0, 4'd10, "g0000");

        // two-cycle glitch to 0001 from committed 0000
        p0      = npulse;
        gray_in = 4'b0001;
        repeat (2) tick();
        gray_in = 4'b0000;
        repeat (20) tick();
        chk("glitch pulses", 32'(npulse - p0), 32'(GLITCH_PULSES));
        chk("glitch bin", 32'(bin_out), 0);
        chk("glitch nuevo", 32'(nuevo), 0);

        // sweep of all codes starting from committed 0000
        p0 = npulse;
        for (int i = 0; i < 16; i++) begin
            gray_in = gcode[i];
            repeat (20) tick();
            chk($sformatf("sweep bin %0d", i), 32'(bin_out), i);
            chk($sformatf("sweep bcd_d %0d", i), 32'(bcd_d), (i >= 10) ? 1 : 0);
            chk($sformatf("sweep bcd_u %0d", i), 32'(bcd_u), (i >= 10) ? i - 10 : i);
        end
        chk("sweep pulses", 32'(npulse - p0), 15);

        // reset while 0011 is still in flight
        gray_in = 4'b0011;
        repeat (PRE_RST) tick();
        p0    = npulse;
        reset = 1'b1;
        tick();
        chk("midrst bin", 32'(bin_out), 0);
        chk("midrst bcd_d", 32'(bcd_d), 0);
        chk("midrst bcd_u", 32'(bcd_u), 0);
        chk("midrst nuevo", 32'(nuevo), 0);
        reset = 1'b0;
        repeat (LAT) tick();
        chk("postrst early bin", 32'(bin_out), 0);
        chk("postrst early nuevo", 32'(nuevo), 0);
        chk("postrst no pulse", 32'(npulse - p0), 0);
        tick();
        chk("postrst bin", 32'(bin_out), 2);
        chk("postrst bcd_d", 32'(bcd_d), 0);
        chk("postrst bcd_u", 32'(bcd_u), 2);
        chk("postrst nuevo", 32'(nuevo), 1);
        tick();
        chk("postrst nuevo drop", 32'(nuevo), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
